ha_array_final_adder: RTL and testbench



---
 rtl/ha_array_final_adder.sv | 156 +++++++++++++++
 tb/tb_ha_array_final_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ha_array_final_adder.sv
// Final adder for the 8x8 approximate multiplier. It captures four half-adder
// row pairs (sum row t_k, carry row b_k) and adds the weighted groups into a
// 17-bit accumulator over several cycles. It then presents the clamped or
// truncated 16-bit product over a valid/ready handshake.
module ha_array_final_adder #(
  parameter int GROUPS_PER_CYCLE = 1,
  parameter bit SATURATE         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        sat
);

  // Only divisors of the four groups give a whole number of ACC cycles.
  if (!(GROUPS_PER_CYCLE == 1 || GROUPS_PER_CYCLE == 2 || GROUPS_PER_CYCLE == 4)) begin : g_bad_gpc
    $error("ha_array_final_adder: GROUPS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [2:0] CNT_STEP = 3'(GROUPS_PER_CYCLE);

  state_t      state, state_nxt;
  logic        capture, add_en, load_out, rel_out;

  logic [8:0]  t_p0 [4];
  logic [6:0]  b_p0 [4];

  logic [16:0] acc_p1;
  logic [2:0]  cnt_p1;
  logic [16:0] add_sum;
  logic [1:0]  idx;
  logic        last_grp;

  // One group: sum row plus carry row (carry bits sit two places higher),
  // both shifted up by the group's 2k base weight.
  function automatic logic [16:0] group_value(input logic [8:0] t,
                                              input logic [6:0] b,
                                              input logic [1:0] k);
    logic [16:0] v;
    v = 17'(t) + (17'(b) << 2);
    return v << {k, 1'b0};
  endfunction

  // Anything above 16 bits is clamped only when SATURATE is set.
  function automatic logic [15:0] clamp16(input logic [16:0] s);
    if (SATURATE && s[16]) return 16'hFFFF;
    else                   return s[15:0];
  endfunction

  // Stage p0: row capture. These registers are data only and load on the accept cycle.
  always_ff @(posedge clk) begin
    if (capture) begin
      t_p0[0] <= ha_array_0_t;
      t_p0[1] <= ha_array_1_t;
      t_p0[2] <= ha_array_2_t;
      t_p0[3] <= ha_array_3_t;
      b_p0[0] <= ha_array_0_b;
      b_p0[1] <= ha_array_1_b;
      b_p0[2] <= ha_array_2_b;
      b_p0[3] <= ha_array_3_b;
    end
  end

  // Sum of the GROUPS_PER_CYCLE groups due this cycle, in ascending k order.
  always_comb begin
    add_sum = '0;
    idx     = '0;
    for (int i = 0; i < GROUPS_PER_CYCLE; i++) begin
      idx     = cnt_p1[1:0] + 2'(i);
      add_sum = add_sum + group_value(t_p0[idx], b_p0[idx], idx);
    end
  end

  assign last_grp = ((cnt_p1 + CNT_STEP) == 3'd4);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control strobes. DONE spends its first cycle loading the output register.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    add_en    = 1'b0;
    load_out  = 1'b0;
    rel_out   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        add_en = 1'b1;
        if (last_grp) state_nxt = DONE;
      end
      DONE: begin
        if (!out_valid) begin
          load_out = 1'b1;
        end else if (out_ready) begin
          rel_out   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: accumulator, group counter and registered handshake/outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1    <= '0;
      cnt_p1    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      sat       <= 1'b0;
    end else begin
      if (capture) begin
        acc_p1   <= '0;
        cnt_p1   <= '0;
        in_ready <= 1'b0;
      end else if (add_en) begin
        acc_p1 <= acc_p1 + add_sum;
        cnt_p1 <= cnt_p1 + CNT_STEP;
      end
      if (load_out) begin
        product   <= clamp16(acc_p1);
        sat       <= acc_p1[16];
        out_valid <= 1'b1;
      end
      if (rel_out) begin
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ha_array_final_adder.sv
// Directed bench for ha_array_final_adder. It uses four instances:
// GROUPS_PER_CYCLE 1/2/4 with saturation, plus GROUPS_PER_CYCLE 1 with truncation.
module tb_ha_array_final_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  in_valid_v;
  logic [3:0]  out_ready_v;
  logic [8:0]  t0, t1, t2, t3;
  logic [6:0]  b0, b1, b2, b3;
  wire  [3:0]  in_ready_v;
  wire  [3:0]  out_valid_v;
  wire  [3:0]  sat_v;
  wire  [15:0] product_v [4];

  int n_checks = 0;
  int n_errors = 0;

  ha_array_final_adder #(.GROUPS_PER_CYCLE(1), .SATURATE(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .product(product_v[0]), .sat(sat_v[0]));

  ha_array_final_adder #(.GROUPS_PER_CYCLE(2), .SATURATE(1)) u_g2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .product(product_v[1]), .sat(sat_v[1]));

  ha_array_final_adder #(.GROUPS_PER_CYCLE(4), .SATURATE(1)) u_g4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .product(product_v[2]), .sat(sat_v[2]));

  ha_array_final_adder #(.GROUPS_PER_CYCLE(1), .SATURATE(0)) u_g1_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .product(product_v[3]), .sat(sat_v[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rows(input logic [8:0] a0, input logic [8:0] a1,
                          input logic [8:0] a2, input logic [8:0] a3,
                          input logic [6:0] c0, input logic [6:0] c1,
                          input logic [6:0] c2, input logic [6:0] c3);
    t0 = a0; t1 = a1; t2 = a2; t3 = a3;
    b0 = c0; b1 = c1; b2 = c2; b3 = c3;
  endtask

  // One full transaction on instance s. Rows are scrambled right after capture.
  // When hold is set, DONE is held for 10 cycles while in_valid is pulsed.
  task automatic run_txn(input int s, input string tag, input logic [15:0] exp_p,
                         input logic exp_s, input int lat, input bit hold);
    int n;
    logic [15:0] p_seen;
    check({tag, ".in_ready_idle"}, 32'(in_ready_v[s]), 32'd1);
    in_valid_v[s] = 1'b1;
    tick();
    in_valid_v[s] = 1'b0;
    set_rows(9'h155, 9'h0AA, 9'h1F0, 9'h00F, 7'h55, 7'h2A, 7'h70, 7'h0F);
    n = 0;
    while (!out_valid_v[s] && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".product"}, 32'(product_v[s]), 32'(exp_p));
    check({tag, ".sat"}, 32'(sat_v[s]), 32'(exp_s));
    check({tag, ".in_ready_busy"}, 32'(in_ready_v[s]), 32'd0);
    if (hold) begin
      p_seen = product_v[s];
      for (int k = 0; k < 10; k++) begin
        in_valid_v[s] = (k % 3 == 0);
        tick();
        check({tag, ".hold_product"}, 32'(product_v[s]), 32'(exp_p));
        check({tag, ".hold_valid"}, 32'(out_valid_v[s]), 32'd1);
        check({tag, ".hold_in_ready"}, 32'(in_ready_v[s]), 32'd0);
      end
      in_valid_v[s] = 1'b0;
      check({tag, ".hold_stable"}, 32'(product_v[s]), 32'(p_seen));
    end
    out_ready_v[s] = 1'b1;
    tick();
    out_ready_v[s] = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid_v[s]), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready_v[s]), 32'd1);
    if (hold) begin
      tick();
      tick();
      check({tag, ".no_ghost_valid"}, 32'(out_valid_v[s]), 32'd0);
      check({tag, ".still_ready"}, 32'(in_ready_v[s]), 32'd1);
    end
  endtask

  // Reset during the second ACC cycle, then run a fresh transaction.
  task automatic reset_mid(input int s, input int lat);
    set_rows(9'h005, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    in_valid_v[s] = 1'b1;
    tick();
    in_valid_v[s] = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.in_ready", 32'(in_ready_v[s]), 32'd1);
    check("rstmid.out_valid", 32'(out_valid_v[s]), 32'd0);
    check("rstmid.product", 32'(product_v[s]), 32'd0);
    check("rstmid.sat", 32'(sat_v[s]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_rows(9'h002, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    run_txn(s, "after_rst", 16'h0002, 1'b0, lat, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    set_rows(9'h0, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    #12;
    for (int s = 0; s < 4; s++) begin
      check("reset.in_ready", 32'(in_ready_v[s]), 32'd1);
      check("reset.out_valid", 32'(out_valid_v[s]), 32'd0);
      check("reset.product", 32'(product_v[s]), 32'd0);
      check("reset.sat", 32'(sat_v[s]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 3; s++) begin
      lat = (s == 0) ? 5 : (s == 1) ? 3 : 2;
      set_rows(9'h001, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
      run_txn(s, "single", 16'h0001, 1'b0, lat, 1'b0);
      set_rows(9'h0, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h40);
      run_txn(s, "top_carry", 16'h4000, 1'b0, lat, 1'b0);
      set_rows(9'h0, 9'h003, 9'h0, 9'h0, 7'h0, 7'h0, 7'h01, 7'h0);
      run_txn(s, "mixed", 16'h004C, 1'b0, lat, 1'b0);
      set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      run_txn(s, "saturate", 16'hFFFF, 1'b1, lat, 1'b1);
      reset_mid(s, lat);
    end

    set_rows(9'h001, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    run_txn(3, "trunc_single", 16'h0001, 1'b0, 5, 1'b0);
    set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    run_txn(3, "truncate", 16'h5257, 1'b1, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
